pc_fetch: RTL and testbench

//   Program-counter and instruction-fetch stage; consumes doBranch from the branch unit.

---
 rtl/rv32_pkg.sv | 35 +++
 rtl/pc_target.sv | 45 ++++
 rtl/pc_fetch.sv | 174 +++++++++++++++++
 tb/tb_pc_fetch.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RV32 front end and execute stage:
//   - branch-unit operation encodings (bruop_e)
//   - fetch FSM state encoding (fetch_state_e)
//   - datapath width, reset PC and canonical NOP constants
// No ports; imported with "import rv32_pkg::*;".
// ---------------------------------------------------------------------------
package rv32_pkg;

    localparam int          RV32_XLEN        = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [31:0] NOP              = 32'h0000_0013;

    typedef enum logic [2:0] {
        BRU_EQ,
        BRU_NE,
        BRU_LT,
        BRU_GE,
        BRU_LTU,
        BRU_GEU,
        BRU_JMP,
        BRU_OFF
    } bruop_e;

    // S_HALT is only entered when misaligned-target trapping is built in.
    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HALT
    } fetch_state_e;

endpackage

// File: rtl/pc_target.sv
// ---------------------------------------------------------------------------
// pc_target
// Combinational branch/jump target generator, shared by fetch and execute.
//   target = is_jalr ? (rs1 + imm) & ~1 : br_pc + imm   (wraps mod 2^XLEN)
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : target is passed through; misaligned_o flags target[1] != 0
//   undefined : target[1:0] is forced to 2'b00, no misaligned_o port
// Ports:
//   is_jalr_i     in   1     select rs1 base (JALR) instead of br_pc
//   br_pc_i       in   XLEN  PC of the branch/jump
//   rs1_val_i     in   XLEN  JALR base register
//   imm_i         in   XLEN  sign-extended immediate
//   target_o      out  XLEN  redirect target
//   misaligned_o  out  1     [MISALIGN_TRAP_EN] target not 4-byte aligned
// ---------------------------------------------------------------------------
module pc_target #(
    parameter int XLEN = 32
) (
    input  logic            is_jalr_i,
    input  logic [XLEN-1:0] br_pc_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] target_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misaligned_o
`endif
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    assign base = is_jalr_i ? rs1_val_i : br_pc_i;
    assign sum  = base + imm_i;

`ifdef MISALIGN_TRAP_EN
    // JALR clears bit 0 architecturally; bit 1 is left for the trap check.
    assign target_o     = is_jalr_i ? (sum & ~XLEN'(1)) : sum;
    assign misaligned_o = target_o[1];
`else
    // Without trapping, silently align to a word boundary.
    assign target_o = sum & ~XLEN'(3);
`endif

endmodule

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
// Program counter and instruction fetch stage. Issues one outstanding request
// at a time to instruction memory, buffers the returned word in a 1-entry
// valid/ready register towards decode, and applies branch/jump redirects
// coming from execute (redirect = ex_valid & doBranch).
// Optional feature macro: MISALIGN_TRAP_EN (misaligned-target trap + halt).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_valid, doBranch        redirect request from execute / branch unit
//   ex_is_jalr, br_pc,
//   rs1_val, imm              redirect target operands
//   imem_req, imem_addr       fetch request (address = pc)
//   imem_gnt                  request accepted this cycle
//   imem_rvalid, imem_rdata   fetch response (one per granted request)
//   if_valid, if_instr, if_pc buffered instruction towards decode
//   id_ready                  decode accepts the buffered instruction
//   misalign_trap             [MISALIGN_TRAP_EN] 1-cycle trap pulse
//   misalign_addr             [MISALIGN_TRAP_EN] offending target, held
// ---------------------------------------------------------------------------
module pc_fetch
    import rv32_pkg::*;
#(
    parameter int              XLEN     = RV32_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            doBranch,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] imm,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap,
    output logic [XLEN-1:0] misalign_addr
`endif
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            ifValid_q;
    logic [31:0]     ifInstr_q;
    logic [XLEN-1:0] ifPc_q;

    logic            redirect;
    logic            bufFree;
    logic [XLEN-1:0] target;
    fetch_state_e    redirState_d;

`ifdef MISALIGN_TRAP_EN
    logic            tgtMisaligned;
    logic            misalignTrap_q;
    logic [XLEN-1:0] misalignAddr_q;
`endif

    pc_target #(
        .XLEN (XLEN)
    ) u_pc_target (
        .is_jalr_i    (ex_is_jalr),
        .br_pc_i      (br_pc),
        .rs1_val_i    (rs1_val),
        .imm_i        (imm),
        .target_o     (target)
`ifdef MISALIGN_TRAP_EN
        ,
        .misaligned_o (tgtMisaligned)
`endif
    );

    assign redirect = ex_valid & doBranch;
    // The buffer can take a new word if it is empty or being drained now.
    assign bufFree  = !ifValid_q | id_ready;

    // A redirect suppresses the request so the stale pc is never fetched;
    // the target is requested the following cycle.
    assign imem_req  = !rst && (state_q == S_REQ) && bufFree && !redirect;
    assign imem_addr = pc_q;
    assign if_valid  = ifValid_q;
    assign if_instr  = ifInstr_q;
    assign if_pc     = ifPc_q;

`ifdef MISALIGN_TRAP_EN
    assign misalign_trap = misalignTrap_q;
    assign misalign_addr = misalignAddr_q;
`endif

    // Where a redirect leaves the FSM: a response still owed by memory has
    // to be swallowed in S_DROP, unless it is arriving this very cycle.
    always_comb begin
        redirState_d = S_REQ;
        if ((state_q == S_WAIT || state_q == S_DROP) && !imem_rvalid) begin
            redirState_d = S_DROP;
        end
    end

    // Fetch FSM, pc and decode buffer. Redirect outranks all normal traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            ifValid_q <= 1'b0;
            ifInstr_q <= '0;
            ifPc_q    <= '0;
`ifdef MISALIGN_TRAP_EN
            misalignTrap_q <= 1'b0;
            misalignAddr_q <= '0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            misalignTrap_q <= 1'b0;
`endif
            if (state_q == S_HALT) begin
                // Parked until reset; any late response is ignored.
                ifValid_q <= 1'b0;
            end else if (redirect) begin
                ifValid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                if (tgtMisaligned) begin
                    misalignTrap_q <= 1'b1;
                    misalignAddr_q <= target;
                    state_q        <= S_HALT;
                end else begin
                    pc_q    <= target;
                    state_q <= redirState_d;
                end
`else
                pc_q    <= target;
                state_q <= redirState_d;
`endif
            end else begin
                if (ifValid_q && id_ready) begin
                    ifValid_q <= 1'b0;
                end
                case (state_q)
                    S_REQ: begin
                        if (imem_req && imem_gnt) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            ifValid_q <= 1'b1;
                            ifInstr_q <= imem_rdata;
                            ifPc_q    <= pc_q;
                            pc_q      <= pc_q + XLEN'(4);
                            state_q   <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (imem_rvalid) begin
                            state_q <= S_REQ;
                        end
                    end
                    default: begin
                        state_q <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
// Directed testbench for pc_fetch. Inputs change 1ns after the rising edge,
// outputs are sampled 1ns later, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        doBranch;
    logic        ex_is_jalr;
    logic [31:0] br_pc;
    logic [31:0] rs1_val;
    logic [31:0] imm;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic [31:0] misalign_addr;
`endif

    int vecCount  = 0;
    int missCount = 0;

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .doBranch    (doBranch),
        .ex_is_jalr  (ex_is_jalr),
        .br_pc       (br_pc),
        .rs1_val     (rs1_val),
        .imm         (imm),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_trap (misalign_trap),
        .misalign_addr (misalign_addr)
`endif
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive memory-side inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic gnt, input logic rv, input logic [31:0] rd);
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
    endtask

    task automatic setRedirect(input logic jalr, input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] im);
        ex_valid   = 1'b1;
        doBranch   = 1'b1;
        ex_is_jalr = jalr;
        br_pc      = pc;
        rs1_val    = rs1;
        imm        = im;
    endtask

    task automatic clearRedirect();
        ex_valid   = 1'b0;
        doBranch   = 1'b0;
        ex_is_jalr = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearRedirect();
        id_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // From S_REQ with a free buffer: one granted request, response a cycle later.
    task automatic fetchOne(input logic [31:0] word);
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, word);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearRedirect();
        id_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL reset_req: got %0b, expected 0", imem_req);
        end
        vecCount++;
        if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
            missCount++; $display("[TB] FAIL reset_buf: got v=%0b i=%h pc=%h, expected 0/0/0", if_valid, if_instr, if_pc);
        end
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            missCount++; $display("[TB] FAIL reset_first_req: got req=%0b addr=%h, expected 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential_fetch();
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (imem_addr !== 32'h0) begin
            missCount++; $display("[TB] FAIL seq_addr0: got %h, expected 00000000", imem_addr);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 32'hA000_0000);
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL seq_wait_req: got %0b, expected 0", imem_req);
        end
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'hA000_0000) begin
            missCount++; $display("[TB] FAIL seq_out0: got v=%0b pc=%h i=%h, expected 1/00000000/a0000000", if_valid, if_pc, if_instr);
        end
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            missCount++; $display("[TB] FAIL seq_addr4: got req=%0b addr=%h, expected 1/00000004", imem_req, imem_addr);
        end
        tick();
        applyStimulus(1'b0, 1'b1, 32'hA000_0004);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'hA000_0004) begin
            missCount++; $display("[TB] FAIL seq_out1: got v=%0b pc=%h i=%h, expected 1/00000004/a0000004", if_valid, if_pc, if_instr);
        end
        vecCount++;
        if (imem_addr !== 32'h8) begin
            missCount++; $display("[TB] FAIL seq_addr8: got %h, expected 00000008", imem_addr);
        end
    endtask

    task automatic test_backpressure();
        doReset();
        id_ready = 1'b0;
        fetchOne(32'hB000_0000);
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL bp_req_full: got %0b, expected 0", imem_req);
        end
        tick();
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b1 || if_instr !== 32'hB000_0000 || imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL bp_hold: got v=%0b i=%h req=%0b, expected 1/b0000000/0", if_valid, if_instr, imem_req);
        end
        id_ready = 1'b1;
        #1;
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            missCount++; $display("[TB] FAIL bp_release_req: got req=%0b addr=%h, expected 1/00000004", imem_req, imem_addr);
        end
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL bp_drained: got %0b, expected 0", if_valid);
        end
        applyStimulus(1'b0, 1'b1, 32'hB000_0004);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'hB000_0004) begin
            missCount++; $display("[TB] FAIL bp_resume: got v=%0b pc=%h i=%h, expected 1/00000004/b0000004", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect_wait();
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        setRedirect(1'b0, 32'h100, 32'h0, 32'h20);
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL rw_req: got %0b, expected 0", imem_req);
        end
        tick();
        clearRedirect();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL rw_drop_req: got %0b, expected 0", imem_req);
        end
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL rw_discard: got %0b, expected 0", if_valid);
        end
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h120) begin
            missCount++; $display("[TB] FAIL rw_target: got req=%0b addr=%h, expected 1/00000120", imem_req, imem_addr);
        end
        tick();
        applyStimulus(1'b0, 1'b1, 32'hC000_0120);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b1 || if_pc !== 32'h120 || if_instr !== 32'hC000_0120) begin
            missCount++; $display("[TB] FAIL rw_fetch: got v=%0b pc=%h i=%h, expected 1/00000120/c0000120", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect_req_latency();
        doReset();
        setRedirect(1'b0, 32'h40, 32'h0, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL lat_suppress: got %0b, expected 0", imem_req);
        end
        tick();
        clearRedirect();
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h38) begin
            missCount++; $display("[TB] FAIL lat_next: got req=%0b addr=%h, expected 1/00000038", imem_req, imem_addr);
        end
        // Target wraps past the top of the address space.
        setRedirect(1'b0, 32'hFFFF_FFF0, 32'h0, 32'h20);
        tick();
        clearRedirect();
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (imem_addr !== 32'h10) begin
            missCount++; $display("[TB] FAIL lat_wrap: got %h, expected 00000010", imem_addr);
        end
    endtask

    task automatic test_jalr_same_cycle();
        doReset();
        fetchOne(32'hD000_0000);
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        setRedirect(1'b1, 32'h0, 32'h2001, 32'h4);
        applyStimulus(1'b0, 1'b1, 32'h0BAD_0BAD);
        id_ready = 1'b0;
        tick();
        clearRedirect();
        id_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL jalr_drop: got %0b, expected 0", if_valid);
        end
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h2004) begin
            missCount++; $display("[TB] FAIL jalr_target: got req=%0b addr=%h, expected 1/00002004", imem_req, imem_addr);
        end
`ifndef MISALIGN_TRAP_EN
        // Without trapping, bit 1 of the target is masked off.
        setRedirect(1'b1, 32'h0, 32'h3003, 32'h0);
        tick();
        clearRedirect();
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (imem_addr !== 32'h3000) begin
            missCount++; $display("[TB] FAIL jalr_align: got %h, expected 00003000", imem_addr);
        end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        doReset();
        fetchOne(32'hE000_0000);
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL rst_mid_req: got %0b, expected 0", imem_req);
        end
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h5555_AAAA);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (if_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL rst_stray: got %0b, expected 0", if_valid);
        end
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            missCount++; $display("[TB] FAIL rst_next_req: got req=%0b addr=%h, expected 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        setRedirect(1'b0, 32'h200, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        setRedirect(1'b0, 32'h300, 32'h0, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        clearRedirect();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL b2b_still_drop: got %0b, expected 0", imem_req);
        end
        applyStimulus(1'b0, 1'b1, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        vecCount++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h304 || if_valid !== 1'b0) begin
            missCount++; $display("[TB] FAIL b2b_target: got req=%0b addr=%h v=%0b, expected 1/00000304/0", imem_req, imem_addr, if_valid);
        end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign_trap();
        doReset();
        setRedirect(1'b0, 32'h100, 32'h0, 32'h2);
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        clearRedirect();
        applyStimulus(1'b1, 1'b0, 32'h0);
        vecCount++;
        if (misalign_trap !== 1'b1 || misalign_addr !== 32'h102) begin
            missCount++; $display("[TB] FAIL trap_pulse: got t=%0b a=%h, expected 1/00000102", misalign_trap, misalign_addr);
        end
        vecCount++;
        if (imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL trap_req: got %0b, expected 0", imem_req);
        end
        tick();
        applyStimulus(1'b1, 1'b1, 32'h0);
        vecCount++;
        if (misalign_trap !== 1'b0 || misalign_addr !== 32'h102 || imem_req !== 1'b0) begin
            missCount++; $display("[TB] FAIL trap_halt: got t=%0b a=%h req=%0b, expected 0/00000102/0", misalign_trap, misalign_addr, imem_req);
        end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        ex_valid    = 1'b0;
        doBranch    = 1'b0;
        ex_is_jalr  = 1'b0;
        br_pc       = 32'h0;
        rs1_val     = 32'h0;
        imm         = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b1;

        test_reset();
        test_sequential_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_req_latency();
        test_jalr_same_cycle();
        test_reset_mid_fetch();
        test_back_to_back();
`ifdef MISALIGN_TRAP_EN
        test_misalign_trap();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
